// File: rtl/ft_axi_result_framer_if.sv
// AXI-Stream bundle used on both the result input and the DMA-facing output of the framer.
interface ft_axi_result_framer_if #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDATA_BYTES = TDATA_WIDTH / 8
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TDATA_BYTES-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/ft_axi_result_framer.sv
// Buffers DUT result beats, forwards them with tlast stripped, and closes each frame
// with a trailer beat {xor checksum, sequence number, saturating beat count}.
module ft_axi_result_framer #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDATA_BYTES = TDATA_WIDTH / 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_areset,
  ft_axi_result_framer_if.slave  s_axis,
  ft_axi_result_framer_if.master m_axis,
  output logic [15:0]            frame_cnt_o,
  output logic                   busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_DATA = 1'b0, S_TRAILER = 1'b1} state_t;

  function automatic logic [TDATA_WIDTH-1:0] keep_bytes(input logic [TDATA_WIDTH-1:0] d,
                                                        input logic [TDATA_BYTES-1:0] k);
    logic [TDATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < TDATA_BYTES; i++)
      if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] fold_xor(input logic [TDATA_WIDTH-1:0] d);
    return d[63:32] ^ d[31:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [TDATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            occ, occ_nxt;
  logic                   empty_q, full_q;
  state_t                 state_q, state_nxt;
  logic [31:0]            chk_q;
  logic [15:0]            cnt_q, seq_q;
  logic [TDATA_WIDTH-1:0] head_data;
  logic                   head_last;
  logic                   wr_en, pop, trl_hs;

  assign {head_last, head_data} = mem[rd_ptr];
  assign wr_en  = s_axis.tvalid & ~full_q & ~s_axis_areset;
  assign pop    = (state_q == S_DATA) & ~empty_q & m_axis.tready & ~s_axis_areset;
  assign trl_hs = (state_q == S_TRAILER) & m_axis.tready & ~s_axis_areset;
  assign frame_cnt_o = seq_q;

  always_comb begin
    occ_nxt = occ;
    case ({wr_en, pop})
      2'b10:   occ_nxt = occ + (AW+1)'(1);
      2'b01:   occ_nxt = occ - (AW+1)'(1);
      default: occ_nxt = occ;
    endcase
  end

  // FIFO storage: stored tlast rides above the masked data word
  always_ff @(posedge s_axis_aclk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis.tlast, keep_bytes(s_axis.tdata, s_axis.tkeep)};
  end

  // Flags are registered from the next occupancy, so a fresh write shows one cycle later
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      occ     <= occ_nxt;
      empty_q <= (occ_nxt == '0);
      full_q  <= (occ_nxt == FULL_OCC);
    end
  end

  // Frame accounting: only moves on handshakes, so the presented trailer stays stable
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      chk_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q ^ fold_xor(head_data);
      cnt_q <= sat_inc16(cnt_q);
    end else if (trl_hs) begin
      chk_q <= '0;
      cnt_q <= '0;
      seq_q <= seq_q + 16'd1;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) state_q <= S_DATA;
    else               state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_DATA:    if (pop && head_last) state_nxt = S_TRAILER;
      S_TRAILER: if (trl_hs)           state_nxt = S_DATA;
    endcase
  end

  always_comb begin
    s_axis.tready = ~full_q & ~s_axis_areset;
    m_axis.tkeep  = '1;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tlast  = 1'b0;
    busy_o        = 1'b0;
    if (!s_axis_areset) begin
      busy_o = ~empty_q | (state_q == S_TRAILER);
      if (state_q == S_TRAILER) begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        m_axis.tdata  = {chk_q, seq_q, cnt_q};
      end else begin
        m_axis.tvalid = ~empty_q;
        m_axis.tdata  = head_data;
      end
    end
  end
endmodule

// File: tb/tb_ft_axi_result_framer.sv
// Randomized bench for ft_axi_result_framer against a frame-level reference model.
module tb_ft_axi_result_framer;
  typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  typedef struct packed { logic [63:0] data; logic last; } obeat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_cnt;
  logic        busy;
  int          errors = 0, checks = 0, cyc = 0, acc_cnt = 0, got_base = 0;
  beat_t       stim_q[$];
  obeat_t      exp_q[$];
  obeat_t      got_q[$];
  int          got_cyc[$];
  logic [31:0] m_chk;
  int          m_n;
  logic [15:0] m_seq;

  ft_axi_result_framer_if s_if ();
  ft_axi_result_framer_if m_if ();

  ft_axi_result_framer dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(rst),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .frame_cnt_o  (frame_cnt),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed transfer on both sides, sampled mid-cycle
  always @(negedge clk) begin
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      got_q.push_back('{data: m_if.tdata, last: m_if.tlast});
      got_cyc.push_back(cyc);
    end
    if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) acc_cnt <= acc_cnt + 1;
  end

  function automatic obeat_t got_at(int i);
    obeat_t r;
    r = 'x;
    if (got_base + i < got_q.size()) r = got_q[got_base + i];
    return r;
  endfunction

  task automatic add_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    stim_q.push_back('{data: d, keep: k, last: l});
  endtask

  task automatic model_clear();
    m_chk = '0;
    m_n   = 0;
    m_seq = '0;
    exp_q.delete();
  endtask

  // Reference: masked beats pass through, each frame closes with {xor, seq, count}
  task automatic model_stim();
    logic [63:0] d;
    foreach (stim_q[i]) begin
      d = '0;
      for (int b = 0; b < 8; b++) if (stim_q[i].keep[b]) d[b*8 +: 8] = stim_q[i].data[b*8 +: 8];
      exp_q.push_back('{data: d, last: 1'b0});
      m_chk = m_chk ^ d[63:32] ^ d[31:0];
      if (m_n < 65535) m_n++;
      if (stim_q[i].last) begin
        exp_q.push_back('{data: {m_chk, m_seq, 16'(m_n)}, last: 1'b1});
        m_seq = m_seq + 16'd1;
        m_chk = '0;
        m_n   = 0;
      end
    end
  endtask

  task automatic send_stim();
    int t;
    foreach (stim_q[i]) begin
      s_if.tdata  = stim_q[i].data;
      s_if.tkeep  = stim_q[i].keep;
      s_if.tlast  = stim_q[i].last;
      s_if.tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (s_if.tready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      if (s_if.tready !== 1'b1) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat %0d not accepted, tready=%b required 1", i, s_if.tready);
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_q.size() - got_base < n && t < 1000) begin @(negedge clk); t++; end
    checks++;
    if (got_q.size() - got_base < n) begin
      errors++;
      $display("FAIL wait_out: got %0d beats, required %0d", got_q.size() - got_base, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    got_base = got_q.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 64'hDEAD_BEEF_0123_4567;
    s_if.tkeep  = 8'hFF;
    s_if.tlast  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b required 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b required 0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 64'h0) begin errors++; $display("FAIL reset_m_tdata: got %h required 0", m_if.tdata); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %b required 0", m_if.tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    s_if.tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready: got %b required 1", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_m_tvalid: got %b required 0", m_if.tvalid); end
  endtask

  task automatic test_single_frame();
    obeat_t g;
    apply_reset();
    m_if.tready = 1'b1;
    stim_q.delete();
    add_beat(64'h1111_1111_0000_0001, 8'hFF, 1'b0);
    add_beat(64'h0000_0002_0000_0000, 8'hFF, 1'b0);
    add_beat(64'h0000_0000_0000_0003, 8'hFF, 1'b1);
    model_stim();
    send_stim();
    wait_out(exp_q.size());
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() - got_base != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d beats required %0d", got_q.size() - got_base, exp_q.size()); end
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
    g = got_at(3);
    checks++; if (g !== '{data: 64'h1111_1111_0000_0003, last: 1'b1}) begin errors++; $display("FAIL single_trailer: got %h last=%b required 1111111100000003 last=1", g.data, g.last); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_keep();
    obeat_t g;
    apply_reset();
    m_if.tready = 1'b1;
    stim_q.delete();
    add_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
    for (int i = 0; i < 4; i++) add_beat({$urandom, $urandom}, 8'($urandom), i == 3);
    model_stim();
    send_stim();
    wait_out(exp_q.size());
    g = got_at(0);
    checks++; if (g !== '{data: 64'h0000_0000_FFFF_FFFF, last: 1'b0}) begin errors++; $display("FAIL keep_data: got %h last=%b required 00000000ffffffff last=0", g.data, g.last); end
    g = got_at(1);
    checks++; if (g !== '{data: 64'hFFFF_FFFF_0000_0001, last: 1'b1}) begin errors++; $display("FAIL keep_trailer: got %h last=%b required ffffffff00000001 last=1", g.data, g.last); end
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL keep_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
  endtask

  task automatic test_backpressure();
    int a0;
    logic gap;
    obeat_t g;
    apply_reset();
    m_if.tready = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 17; i++) add_beat({$urandom, $urandom}, 8'($urandom), 1'b0);
    model_stim();
    a0 = acc_cnt;
    fork
      send_stim();
      begin
        repeat (30) @(negedge clk);
        checks++; if (acc_cnt - a0 != 16) begin errors++; $display("FAIL bp_accepted: got %0d required 16", acc_cnt - a0); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready: got %b required 0", s_if.tready); end
        checks++; if (s_if.tvalid !== 1'b1) begin errors++; $display("FAIL bp_held_upstream: tvalid %b required 1", s_if.tvalid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b required 1", busy); end
        checks++; if (got_q.size() != got_base) begin errors++; $display("FAIL bp_leak: got %0d beats required 0", got_q.size() - got_base); end
        @(posedge clk); #1 m_if.tready = 1'b1;
      end
    join
    wait_out(17);
    repeat (3) @(negedge clk);
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
    gap = (got_q.size() - got_base < 17);
    if (!gap) for (int i = 1; i < 17; i++) if (got_cyc[got_base + i] != got_cyc[got_base] + i) gap = 1'b1;
    checks++; if (gap) begin errors++; $display("FAIL bp_gapless: gap seen in drain, required 17 consecutive beats"); end
  endtask

  task automatic test_back_to_back();
    logic gap;
    obeat_t g;
    apply_reset();
    m_if.tready = 1'b1;
    stim_q.delete();
    add_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    add_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    add_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    model_stim();
    send_stim();
    wait_out(5);
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
    g = got_at(2);
    checks++; if (g.data[31:0] !== 32'h0000_0002) begin errors++; $display("FAIL b2b_trailer0_seq_cnt: got %h required 00000002", g.data[31:0]); end
    g = got_at(4);
    checks++; if (g.data[31:0] !== 32'h0001_0001) begin errors++; $display("FAIL b2b_trailer1_seq_cnt: got %h required 00010001", g.data[31:0]); end
    gap = (got_q.size() - got_base < 5);
    if (!gap) for (int i = 1; i < 5; i++) if (got_cyc[got_base + i] != got_cyc[got_base] + i) gap = 1'b1;
    checks++; if (gap) begin errors++; $display("FAIL b2b_gapless: gap seen, required 5 consecutive beats"); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_trailer_stall();
    obeat_t ref_b, g;
    logic   ref_v;
    int     a0, t;
    apply_reset();
    m_if.tready = 1'b0;
    stim_q.delete();
    add_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    add_beat({$urandom, $urandom}, 8'($urandom), 1'b1);
    model_stim();
    send_stim();
    m_if.tready = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end
    while (!(m_if.tvalid === 1'b1 && m_if.tlast === 1'b1) && t < 50);
    m_if.tready = 1'b0;
    ref_b = '{data: m_if.tdata, last: m_if.tlast};
    ref_v = m_if.tvalid;
    checks++; if (ref_b !== exp_q[2] || ref_v !== 1'b1) begin errors++; $display("FAIL stall_trailer: got %h last=%b valid=%b required %h last=1 valid=1", ref_b.data, ref_b.last, ref_v, exp_q[2].data); end
    stim_q.delete();
    for (int i = 0; i < 3; i++) add_beat({$urandom, $urandom}, 8'hFF, i == 2);
    model_stim();
    a0 = acc_cnt;
    fork
      send_stim();
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== {ref_v, ref_b.last, ref_b.data}) begin
          errors++;
          $display("FAIL stall_hold%0d: got %b/%b/%h required %b/%b/%h", k, m_if.tvalid, m_if.tlast, m_if.tdata, ref_v, ref_b.last, ref_b.data);
        end
      end
    join
    @(negedge clk);
    checks++; if (acc_cnt - a0 != 3) begin errors++; $display("FAIL stall_input_accept: got %0d required 3", acc_cnt - a0); end
    checks++; if (got_q.size() - got_base != 2) begin errors++; $display("FAIL stall_no_transfer: got %0d beats required 2", got_q.size() - got_base); end
    @(posedge clk); #1 m_if.tready = 1'b1;
    wait_out(exp_q.size());
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() - got_base != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d beats required %0d", got_q.size() - got_base, exp_q.size()); end
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stall_frame_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    obeat_t g;
    apply_reset();
    m_if.tready = 1'b1;
    stim_q.delete();
    add_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    model_stim();
    send_stim();
    wait_out(2);
    m_if.tready = 1'b0;
    stim_q.delete();
    add_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    add_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_stim();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    got_base = got_q.size();
    m_if.tready = 1'b1;
    stim_q.delete();
    add_beat(64'h0000_0000_0000_00AA, 8'hFF, 1'b1);
    model_stim();
    send_stim();
    wait_out(2);
    repeat (10) @(negedge clk);
    checks++; if (got_q.size() - got_base != 2) begin errors++; $display("FAIL rmid_count: got %0d beats required 2", got_q.size() - got_base); end
    g = got_at(0);
    checks++; if (g !== '{data: 64'h0000_0000_0000_00AA, last: 1'b0}) begin errors++; $display("FAIL rmid_data: got %h last=%b required 00000000000000aa last=0", g.data, g.last); end
    g = got_at(1);
    checks++; if (g !== '{data: 64'h0000_00AA_0000_0001, last: 1'b1}) begin errors++; $display("FAIL rmid_trailer: got %h last=%b required 000000aa00000001 last=1", g.data, g.last); end
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rmid_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_random();
    logic   sent;
    int     len;
    obeat_t g;
    apply_reset();
    stim_q.delete();
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) add_beat({$urandom, $urandom}, 8'($urandom), b == len - 1);
    end
    model_stim();
    sent = 1'b0;
    fork
      begin send_stim(); sent = 1'b1; end
      while (!sent) begin @(posedge clk); #1; m_if.tready = 1'($urandom_range(0, 1)); end
    join
    m_if.tready = 1'b1;
    wait_out(exp_q.size());
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() - got_base != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d beats required %0d", got_q.size() - got_base, exp_q.size()); end
    foreach (exp_q[i]) begin
      g = got_at(i);
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h last=%b required %h last=%b", i, g.data, g.last, exp_q[i].data, exp_q[i].last); end
    end
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL rand_frame_cnt: got %0d required 6", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle_busy: got %b required 0", busy); end
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    test_reset();
    test_single_frame();
    test_keep();
    test_backpressure();
    test_back_to_back();
    test_trailer_stall();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
